mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/samsun_pkg.sv | 29 ++
 rtl/load_extend.sv | 34 +++
 rtl/mem_stage.sv | 178 +++++++++++++++++
 tb/tb_mem_stage.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/samsun_pkg.sv
// Shared definitions for the memory stage: RV32I load/store funct3 codes,
// writeback source encoding and the memory-stage FSM state type.
package samsun_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC   = 2'b10,
    WB_NONE = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } mem_state_e;

  // funct3 codes with no defined load/store meaning
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module load_extend
  import samsun_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select by address offset, then extension by funct3
  always_comb begin
    byte_sel = 8'h00;
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    case (funct3_i)
      F3_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result_o = {{16{half_sel[15]}}, half_sel};
      F3_W:    result_o = rdata_i;
      F3_BU:   result_o = {24'h0, byte_sel};
      F3_HU:   result_o = {16'h0, half_sel};
      default: result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: issues data-memory requests, waits for grant and
// read data, and registers the writeback to the register file.
//
// Handshake: dmem_req_o is held with constant addr/we/wdata/wstrb until a
// cycle with dmem_gnt_i=1; a granted load then waits for dmem_rvalid_i
// (earliest the cycle after the grant). Upstream holds all mem_* inputs
// stable while mem_ready_o=0; an instruction completes in the cycle where
// mem_valid_i=1 and mem_ready_o=1.
module mem_stage
  import samsun_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  mem_funct3_i,
  input  logic        mem_reg_write_i,
  input  logic [1:0]  mem_wb_sel_i,
  input  logic [31:0] mem_aluResult_i,
  input  logic [31:0] mem_data_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic [31:0] mem_pcplus_i,
  output logic        mem_ready_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_rd_o,
  output logic        wb_rd_en_o,
  output logic        misaligned_o,
  output logic [1:0]  state_o
);

  mem_state_e  state_q, state_d;
  logic        is_access;
  logic        is_store;
  logic [1:0]  offset;
  logic        misalign_c;
  logic        bad_c;
  logic        req_c;
  logic        ready_c;
  logic        fire;
  logic [31:0] load_data;
  logic [31:0] wb_data_c;

  // A set write flag wins over a set read flag
  assign is_access = mem_valid_i & (mem_read_i | mem_write_i);
  assign is_store  = mem_write_i;
  assign offset    = mem_aluResult_i[1:0];

  // Alignment check by access size (funct3[1:0]: 00 byte, 01 half, 10 word)
  always_comb begin
    misalign_c = 1'b0;
    case (mem_funct3_i[1:0])
      2'b01:   misalign_c = offset[0];
      2'b10:   misalign_c = (offset != 2'b00);
      default: misalign_c = 1'b0;
    endcase
  end

  assign bad_c = is_access & (misalign_c | f3_illegal(mem_funct3_i));

  // FSM next state, request and ready generation
  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    ready_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!is_access || bad_c) begin
          ready_c = 1'b1;
        end else begin
          req_c = 1'b1;
          if (dmem_gnt_i) begin
            if (is_store) ready_c = 1'b1;
            else          state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        req_c = 1'b1;
        if (dmem_gnt_i) begin
          if (is_store) begin
            ready_c = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid_i) begin
          ready_c = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Store lane replication and byte strobes
  always_comb begin
    dmem_wdata_o = mem_data_i;
    dmem_wstrb_o = 4'b1111;
    case (mem_funct3_i[1:0])
      2'b00: begin
        dmem_wdata_o = {4{mem_data_i[7:0]}};
        dmem_wstrb_o = 4'b0001 << offset;
      end
      2'b01: begin
        dmem_wdata_o = {2{mem_data_i[15:0]}};
        dmem_wstrb_o = 4'b0011 << offset;
      end
      default: begin
        dmem_wdata_o = mem_data_i;
        dmem_wstrb_o = 4'b1111;
      end
    endcase
  end

  // Reset drops an outstanding request in the same cycle
  assign dmem_req_o  = req_c & ~rst_i;
  assign dmem_we_o   = is_store;
  assign dmem_addr_o = {mem_aluResult_i[31:2], 2'b00};
  assign mem_ready_o = ready_c;
  assign state_o     = state_q;

  load_extend u_load_extend (
    .rdata_i  (dmem_rdata_i),
    .offset_i (offset),
    .funct3_i (mem_funct3_i),
    .result_o (load_data)
  );

  // Writeback source select; the unused encoding writes zero
  always_comb begin
    case (wb_sel_e'(mem_wb_sel_i))
      WB_ALU:  wb_data_c = mem_aluResult_i;
      WB_LOAD: wb_data_c = load_data;
      WB_PC:   wb_data_c = mem_pcplus_i;
      default: wb_data_c = 32'h0;
    endcase
  end

  assign fire = mem_valid_i & ready_c;

  // Registered writeback and misalignment pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_rd_en_o   <= 1'b0;
      wb_rd_addr_o <= 5'd0;
      wb_rd_o      <= 32'h0;
      misaligned_o <= 1'b0;
    end else begin
      wb_rd_en_o   <= fire & mem_reg_write_i & (mem_rd_addr_i != 5'd0) & ~bad_c;
      misaligned_o <= fire & bad_c;
      if (fire) begin
        wb_rd_addr_o <= mem_rd_addr_i;
        wb_rd_o      <= wb_data_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomised
// grant/rvalid latencies, with a writeback scoreboard queue.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        mem_valid, mem_read, mem_write, mem_reg_write;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu, mem_data, mem_pc;
  logic [4:0]  mem_rd;
  logic        mem_ready_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_rd_o;
  logic        wb_rd_en_o, misaligned_o;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];

  mem_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .mem_valid_i     (mem_valid),
    .mem_read_i      (mem_read),
    .mem_write_i     (mem_write),
    .mem_funct3_i    (mem_funct3),
    .mem_reg_write_i (mem_reg_write),
    .mem_wb_sel_i    (mem_wb_sel),
    .mem_aluResult_i (mem_alu),
    .mem_data_i      (mem_data),
    .mem_rd_addr_i   (mem_rd),
    .mem_pcplus_i    (mem_pc),
    .mem_ready_o     (mem_ready_o),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_wstrb_o    (dmem_wstrb_o),
    .dmem_gnt_i      (dmem_gnt),
    .dmem_rvalid_i   (dmem_rvalid),
    .dmem_rdata_i    (dmem_rdata),
    .wb_rd_addr_o    (wb_rd_addr_o),
    .wb_rd_o         (wb_rd_o),
    .wb_rd_en_o      (wb_rd_en_o),
    .misaligned_o    (misaligned_o),
    .state_o         (state_o)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_idle();
    mem_valid = 0; mem_read = 0; mem_write = 0; mem_reg_write = 0;
    mem_funct3 = 3'b000; mem_wb_sel = 2'b00; mem_alu = 0; mem_data = 0;
    mem_rd = 0; mem_pc = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  // Drives one instruction and acts as the data memory: grants after
  // gnt_delay request cycles, returns rvalid rv_delay cycles after a load grant.
  // Returns at the negedge after completion with inputs idle.
  task automatic do_access(
    input  logic rd_en, input logic wr_en, input logic [2:0] f3,
    input  logic regw, input logic [1:0] sel, input logic [31:0] alu,
    input  logic [31:0] sdata, input logic [4:0] rd, input logic [31:0] pc,
    input  logic [31:0] rword, input int gnt_delay, input int rv_delay,
    output int req_cycles, output int busy_cycles, output logic hold_ok,
    output logic [31:0] seen_addr, output logic [31:0] seen_wdata,
    output logic [3:0] seen_wstrb, output logic seen_we, output logic timed_out);
    int   req_idx;
    int   wait_idx;
    logic load_granted;
    logic done;
    @(negedge clk);
    mem_valid = 1; mem_read = rd_en; mem_write = wr_en; mem_funct3 = f3;
    mem_reg_write = regw; mem_wb_sel = sel; mem_alu = alu; mem_data = sdata;
    mem_rd = rd; mem_pc = pc; dmem_gnt = 0; dmem_rvalid = 0;
    req_idx = 0; wait_idx = 0; load_granted = 0; done = 0;
    busy_cycles = 0; hold_ok = 1; timed_out = 1;
    seen_addr = 0; seen_wdata = 0; seen_wstrb = 0; seen_we = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (dmem_req_o) begin
        if (req_idx == 0) begin
          seen_addr = dmem_addr_o; seen_wdata = dmem_wdata_o;
          seen_wstrb = dmem_wstrb_o; seen_we = dmem_we_o;
        end else if (dmem_addr_o !== seen_addr || dmem_wdata_o !== seen_wdata ||
                     dmem_wstrb_o !== seen_wstrb || dmem_we_o !== seen_we) begin
          hold_ok = 0;
        end
        if (req_idx == gnt_delay) dmem_gnt = 1;
        req_idx++;
      end else if (load_granted) begin
        if (wait_idx == rv_delay) begin
          dmem_rvalid = 1;
          dmem_rdata = rword;
        end
        wait_idx++;
      end
      #1;
      if (mem_ready_o) done = 1;
      else busy_cycles++;
      if (dmem_gnt && rd_en && !wr_en) load_granted = 1;
      @(posedge clk);
      @(negedge clk);
      dmem_gnt = 0; dmem_rvalid = 0;
      if (done) begin
        timed_out = 0;
        break;
      end
    end
    set_idle();
    req_cycles = req_idx;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if ({wb_rd_en_o, misaligned_o, dmem_req_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got en/mis/req %b expected 000",
                         {wb_rd_en_o, misaligned_o, dmem_req_o});
    end
    n_cmp++;
    if ({wb_rd_addr_o, wb_rd_o} !== 37'h0) begin
      n_fail++; $display("FAIL reset_wb: got rd %0d data %h expected 0/0", wb_rd_addr_o, wb_rd_o);
    end
    n_cmp++;
    if (mem_ready_o !== 1'b1 || state_o !== 2'b00) begin
      n_fail++; $display("FAIL reset_idle: got ready %b state %0d expected 1/0", mem_ready_o, state_o);
    end
    rst = 0;
  endtask

  task automatic test_alu();
    logic [36:0] exp;
    logic [36:0] got;
    @(negedge clk);
    mem_valid = 1; mem_reg_write = 1; mem_wb_sel = 2'b00; mem_alu = 32'h7; mem_rd = 0;
    #1;
    n_cmp++;
    if (mem_ready_o !== 1'b1 || dmem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL alu_ready: got ready %b req %b expected 1/0", mem_ready_o, dmem_req_o);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (wb_rd_en_o !== 1'b0) begin
      n_fail++; $display("FAIL alu_rd0: got wb_rd_en %b expected 0", wb_rd_en_o);
    end
    mem_rd = 3;
    exp_q.push_back({5'd3, 32'h7});
    @(negedge clk);
    set_idle();
    #1;
    got = {wb_rd_addr_o, wb_rd_o};
    exp = exp_q.pop_front();
    n_cmp++;
    if (wb_rd_en_o !== 1'b1 || got !== exp) begin
      n_fail++; $display("FAIL alu_rd3: got en %b rd/data %h expected 1 %h", wb_rd_en_o, got, exp);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (wb_rd_en_o !== 1'b0) begin
      n_fail++; $display("FAIL alu_bubble: got wb_rd_en %b expected 0", wb_rd_en_o);
    end
  endtask

  task automatic test_load_word();
    int rq, bz;
    logic ok, to, we;
    logic [31:0] a, wd;
    logic [3:0] st;
    logic [36:0] exp;
    logic [36:0] got;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    do_access(1, 0, 3'b010, 1, 2'b01, 32'h10, 32'h0, 5'd5, 32'h0, 32'hDEADBEEF, 0, 0,
              rq, bz, ok, a, wd, st, we, to);
    #1;
    n_cmp++;
    if (to || rq != 1 || bz != 1 || a !== 32'h10 || we !== 1'b0) begin
      n_fail++; $display("FAIL lw_timing: got to %b req %0d busy %0d addr %h we %b expected 0 1 1 10 0",
                         to, rq, bz, a, we);
    end
    got = {wb_rd_addr_o, wb_rd_o};
    exp = exp_q.pop_front();
    n_cmp++;
    if (wb_rd_en_o !== 1'b1 || got !== exp) begin
      n_fail++; $display("FAIL lw_wb: got en %b rd/data %h expected 1 %h", wb_rd_en_o, got, exp);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t[6]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
    logic [31:0] adr_t[6] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10, 32'h104};
    logic [31:0] rd_t[6]  = '{32'h80FFFF7F, 32'h80FFFF7F, 32'h80FFFF7F, 32'h80FFFF7F,
                              32'h80FFFF7F, 32'h0};
    logic [31:0] ex_t[6]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF,
                              32'h0000007F, 32'h0};
    int rq, bz;
    logic ok, to, we;
    logic [31:0] a, wd;
    logic [3:0] st;
    logic [36:0] exp;
    logic [36:0] got;
    rd_t[5] = $urandom;
    ex_t[5] = rd_t[5];
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({5'(i + 10), ex_t[i]});
      do_access(1, 0, f3_t[i], 1, 2'b01, adr_t[i], 32'h0, 5'(i + 10), 32'h0, rd_t[i],
                $urandom_range(0, 3), $urandom_range(0, 3), rq, bz, ok, a, wd, st, we, to);
      #1;
      got = {wb_rd_addr_o, wb_rd_o};
      exp = exp_q.pop_front();
      n_cmp++;
      if (to || wb_rd_en_o !== 1'b1 || got !== exp) begin
        n_fail++; $display("FAIL load_%0d: got to %b en %b rd/data %h expected 0 1 %h",
                           i, to, wb_rd_en_o, got, exp);
      end
    end
  endtask

  task automatic test_store();
    int rq, bz;
    logic ok, to, we;
    logic [31:0] a, wd;
    logic [3:0] st;
    do_access(0, 1, 3'b001, 0, 2'b00, 32'h22, 32'h1234ABCD, 5'd0, 32'h0, 32'h0, 3, 0,
              rq, bz, ok, a, wd, st, we, to);
    #1;
    n_cmp++;
    if (to || rq != 4 || bz != 3 || !ok) begin
      n_fail++; $display("FAIL sh_hold: got to %b req %0d busy %0d hold %b expected 0 4 3 1",
                         to, rq, bz, ok);
    end
    n_cmp++;
    if (a !== 32'h20 || wd !== 32'hABCDABCD || st !== 4'b1100 || we !== 1'b1) begin
      n_fail++; $display("FAIL sh_bus: got addr %h wdata %h wstrb %b we %b expected 20 abcdabcd 1100 1",
                         a, wd, st, we);
    end
    n_cmp++;
    if (wb_rd_en_o !== 1'b0) begin
      n_fail++; $display("FAIL sh_wb: got wb_rd_en %b expected 0", wb_rd_en_o);
    end
    // read and write both set behaves as a word store
    do_access(1, 1, 3'b010, 0, 2'b00, 32'h30, 32'hCAFEF00D, 5'd0, 32'h0, 32'h0, 0, 0,
              rq, bz, ok, a, wd, st, we, to);
    #1;
    n_cmp++;
    if (to || bz != 0 || we !== 1'b1 || st !== 4'b1111 || wd !== 32'hCAFEF00D || state_o !== 2'b00) begin
      n_fail++; $display("FAIL rw_store: got busy %0d we %b wstrb %b wdata %h state %0d expected 0 1 1111 cafef00d 0",
                         bz, we, st, wd, state_o);
    end
    // byte store at offset 1
    do_access(0, 1, 3'b000, 0, 2'b00, 32'h41, 32'h000000A5, 5'd0, 32'h0, 32'h0, 1, 0,
              rq, bz, ok, a, wd, st, we, to);
    #1;
    n_cmp++;
    if (to || rq != 2 || a !== 32'h40 || wd !== 32'hA5A5A5A5 || st !== 4'b0010) begin
      n_fail++; $display("FAIL sb_bus: got req %0d addr %h wdata %h wstrb %b expected 2 40 a5a5a5a5 0010",
                         rq, a, wd, st);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3_t[3]  = '{3'b010, 3'b001, 3'b011};
    logic [31:0] adr_t[3] = '{32'h11, 32'h13, 32'h10};
    int rq, bz;
    logic ok, to, we;
    logic [31:0] a, wd;
    logic [3:0] st;
    for (int i = 0; i < 3; i++) begin
      do_access(1, 0, f3_t[i], 1, 2'b01, adr_t[i], 32'h0, 5'd4, 32'h0, 32'h0, 0, 0,
                rq, bz, ok, a, wd, st, we, to);
      #1;
      n_cmp++;
      if (to || rq != 0 || bz != 0 || misaligned_o !== 1'b1 || wb_rd_en_o !== 1'b0) begin
        n_fail++; $display("FAIL misal_%0d: got req %0d busy %0d mis %b en %b expected 0 0 1 0",
                           i, rq, bz, misaligned_o, wb_rd_en_o);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (misaligned_o !== 1'b0) begin
        n_fail++; $display("FAIL misal_pulse_%0d: got %b expected 0", i, misaligned_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] exp;
    logic [36:0] got;
    logic [31:0] v, p;
    logic [1:0]  s;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) begin
        got = {wb_rd_addr_o, wb_rd_o};
        exp = exp_q.pop_front();
        n_cmp++;
        if (wb_rd_en_o !== 1'b1 || got !== exp) begin
          n_fail++; $display("FAIL b2b_%0d: got en %b rd/data %h expected 1 %h", i, wb_rd_en_o, got, exp);
        end
      end
      if (i < 6) begin
        v = $urandom; p = $urandom;
        s = (i % 3 == 0) ? 2'b00 : (i % 3 == 1) ? 2'b10 : 2'b11;
        mem_valid = 1; mem_read = 0; mem_write = 0; mem_reg_write = 1;
        mem_wb_sel = s; mem_alu = v; mem_pc = p; mem_rd = 5'(i + 20);
        exp_q.push_back({5'(i + 20), (s == 2'b00) ? v : (s == 2'b10) ? p : 32'h0});
      end else begin
        set_idle();
      end
    end
  endtask

  task automatic test_reset_abort();
    // reset during WAIT, then a late rvalid
    @(negedge clk);
    mem_valid = 1; mem_read = 1; mem_funct3 = 3'b010; mem_reg_write = 1;
    mem_wb_sel = 2'b01; mem_alu = 32'h40; mem_rd = 5'd7; dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    set_idle();
    dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    #1;
    n_cmp++;
    if (state_o !== 2'b00 || dmem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_wait: got state %0d req %b expected 0/0", state_o, dmem_req_o);
    end
    @(negedge clk);
    dmem_rvalid = 0;
    #1;
    n_cmp++;
    if (wb_rd_en_o !== 1'b0 || wb_rd_addr_o !== 5'd0) begin
      n_fail++; $display("FAIL abort_wb: got en %b rd %0d expected 0/0", wb_rd_en_o, wb_rd_addr_o);
    end
    // reset while a store request is pending drops the request at once
    mem_valid = 1; mem_write = 1; mem_funct3 = 3'b010; mem_alu = 32'h50;
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    n_cmp++;
    if (dmem_req_o !== 1'b0 || state_o !== 2'b01) begin
      n_fail++; $display("FAIL abort_req: got req %b state %0d expected 0/1", dmem_req_o, state_o);
    end
    @(negedge clk);
    rst = 0;
    set_idle();
    #1;
    n_cmp++;
    if (state_o !== 2'b00 || wb_rd_en_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got state %0d en %b expected 0/0", state_o, wb_rd_en_o);
    end
  endtask

  // sequence and report
  initial begin
    rst = 1;
    set_idle();
    test_reset();
    test_alu();
    test_load_word();
    test_loads();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_reset_abort();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
